// File: rtl/bus_pkg.sv
// Shared bus field widths, arbiter state encoding and the read data returned on a bus timeout.
package bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int NUM_M  = 2;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master native valid/ready memory bus: per-master request side plus the shared slave side.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic [NUM_M-1:0]             m_valid;
  logic [NUM_M-1:0]             m_instr;
  logic [NUM_M-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_M-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_M-1:0][STRB_W-1:0] m_wstrb;
  logic [NUM_M-1:0]             m_ready;
  logic [DATA_W-1:0]            m_rdata;

  logic                         s_valid;
  logic                         s_instr;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [STRB_W-1:0]            s_wstrb;
  logic                         s_ready;
  logic [DATA_W-1:0]            s_rdata;

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

  modport arb (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational 2-way round-robin pick; a lone requester always wins, a tie goes to the
// master that was not granted last. No state, no backpressure.
module rr_arbiter (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_pick
);
  assign o_any  = |i_req;
  assign o_pick = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter: 1-cycle grant, combinational ready pass-through,
// forced idle cycle after each transaction, timeout completes hung transfers with an error.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  bus_arbiter_if.arb        bus,
  input  logic              err_clr,
  output logic              err_irq,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_master
);
  localparam int                TCNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_owner;
  logic              r_last;
  logic [TCNT_W-1:0] r_tcnt;

  logic              r_err_irq;
  logic [ADDR_W-1:0] r_err_addr;
  logic              r_err_master;

  logic              w_any;
  logic              w_pick;
  logic              w_err_set;

  logic [NUM_M-1:0]  w_m_ready;
  logic [DATA_W-1:0] w_m_rdata;
  logic              w_s_valid;
  logic              w_s_instr;
  logic [ADDR_W-1:0] w_s_addr;
  logic [DATA_W-1:0] w_s_wdata;
  logic [STRB_W-1:0] w_s_wstrb;

  rr_arbiter u_rr (
    .i_req  (bus.m_valid),
    .i_last (r_last),
    .o_any  (w_any),
    .o_pick (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_m_ready   = '0;
    w_m_rdata   = '0;
    w_s_valid   = 1'b0;
    w_s_instr   = 1'b0;
    w_s_addr    = '0;
    w_s_wdata   = '0;
    w_s_wstrb   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        w_s_valid          = bus.m_valid[r_owner];
        w_s_instr          = bus.m_instr[r_owner];
        w_s_addr           = bus.m_addr[r_owner];
        w_s_wdata          = bus.m_wdata[r_owner];
        w_s_wstrb          = bus.m_wstrb[r_owner];
        w_m_ready[r_owner] = bus.s_ready;
        w_m_rdata          = bus.s_rdata;
        // A master that abandons its request is released silently, not flagged.
        if (bus.s_ready || !bus.m_valid[r_owner]) w_state_nxt = ST_IDLE;
        else if (r_tcnt == TCNT_MAX)              w_state_nxt = ST_ERR;
      end
      ST_ERR: begin
        w_m_ready[r_owner] = 1'b1;
        w_m_rdata          = ERR_RDATA;
        w_err_set          = 1'b1;
        w_state_nxt        = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) begin
        r_owner <= w_pick;
        r_last  <= w_pick;
        r_tcnt  <= '0;
      end else if (r_state == ST_BUSY) begin
        r_tcnt  <= r_tcnt + TCNT_W'(1);
      end
    end
  end

  // A new timeout beats a simultaneous clear, so no error is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_irq    <= 1'b0;
      r_err_addr   <= '0;
      r_err_master <= 1'b0;
    end else if (w_err_set) begin
      r_err_irq <= 1'b1;
      if (!r_err_irq || err_clr) begin
        r_err_addr   <= bus.m_addr[r_owner];
        r_err_master <= r_owner;
      end
    end else if (err_clr) begin
      r_err_irq    <= 1'b0;
      r_err_addr   <= '0;
      r_err_master <= 1'b0;
    end
  end

  assign bus.m_ready = w_m_ready;
  assign bus.m_rdata = w_m_rdata;
  assign bus.s_valid = w_s_valid;
  assign bus.s_instr = w_s_instr;
  assign bus.s_addr  = w_s_addr;
  assign bus.s_wdata = w_s_wdata;
  assign bus.s_wstrb = w_s_wstrb;

  assign err_irq    = r_err_irq;
  assign err_addr   = r_err_addr;
  assign err_master = r_err_master;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requests push expected completions, a negedge
// monitor pops and compares every m_ready pulse and the idle cycle that must follow it.
module tb_bus_arbiter;
  localparam int T = 8;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        err_clr;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_master;

  logic        mv[2];
  logic        mi[2];
  logic [31:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0]  ms[2];
  int          slave_lat;
  int          scnt;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        gap_pend = 1'b0;

  bus_arbiter_if bif ();

  assign bif.m_valid = {mv[1], mv[0]};
  assign bif.m_instr = {mi[1], mi[0]};
  assign bif.m_addr  = {ma[1], ma[0]};
  assign bif.m_wdata = {mw[1], mw[0]};
  assign bif.m_wstrb = {ms[1], ms[0]};

  bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bif),
    .err_clr    (err_clr),
    .err_irq    (err_irq),
    .err_addr   (err_addr),
    .err_master (err_master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_cpl(input int m, input logic [31:0] d);
    exp_t e;
    e.rdy = (m == 0) ? 2'b01 : 2'b10;
    e.dat = d;
    sb_q.push_back(e);
  endfunction

  // Request from master m; n returns the negedge index (0 = issue cycle) of its m_ready.
  task automatic do_req(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ins, output int n);
    logic got;
    got   = 1'b0;
    n     = 0;
    ma[m] = a;
    mw[m] = d;
    ms[m] = s;
    mi[m] = ins;
    mv[m] = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (bif.m_ready[m]) got = 1'b1;
      else n++;
    end
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL req_timeout: master %0d got no m_ready within %0d cycles", m, n);
    end
    @(posedge clk);
    #1;
    mv[m] = 1'b0;
  endtask

  // Slave: s_ready slave_lat cycles after s_valid first appears, rdata = halfword-swapped address.
  initial begin
    bif.s_ready = 1'b0;
    bif.s_rdata = '0;
    scnt        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n || bif.s_ready || !bif.s_valid) begin
        bif.s_ready = 1'b0;
        scnt        = 0;
      end else if (scnt == slave_lat) begin
        bif.s_ready = 1'b1;
        bif.s_rdata = {bif.s_addr[15:0], bif.s_addr[31:16]};
      end else begin
        scnt++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (gap_pend) begin
          chk("idle_gap_s_valid", 32'(bif.s_valid), 32'h0);
          gap_pend = 1'b0;
        end
        if (bif.m_ready != 2'b00) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_cpl: m_ready=%b m_rdata=%h, expected none", bif.m_ready, bif.m_rdata);
          end else begin
            e = sb_q.pop_front();
            chk("cpl_m_ready", 32'(bif.m_ready), 32'(e.rdy));
            chk("cpl_m_rdata", bif.m_rdata, e.dat);
            gap_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1;
    reset_n   = 1'b0;
    err_clr   = 1'b0;
    slave_lat = 1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; mi[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
    end
    #1;
    chk("rst_s_valid",    32'(bif.s_valid),  32'h0);
    chk("rst_m_ready",    32'(bif.m_ready),  32'h0);
    chk("rst_s_addr",     bif.s_addr,        32'h0);
    chk("rst_s_wstrb",    32'(bif.s_wstrb),  32'h0);
    chk("rst_err_irq",    32'(err_irq),      32'h0);
    chk("rst_err_addr",   err_addr,          32'h0);
    chk("rst_err_master", 32'(err_master),   32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: m0, m1, m0, m1.
    expect_cpl(0, 32'h1000_0000);
    expect_cpl(1, 32'h0004_0003);
    expect_cpl(0, 32'h2000_0000);
    expect_cpl(1, 32'h0008_0005);
    fork
      begin
        int n;
        do_req(0, 32'h0000_1000, 32'h0, 4'h0, 1'b1, n);
        do_req(0, 32'h0000_2000, 32'h0, 4'h0, 1'b0, n);
      end
      begin
        int n;
        do_req(1, 32'h0003_0004, 32'hCAFE_0001, 4'hF, 1'b0, n);
        do_req(1, 32'h0005_0008, 32'hCAFE_0002, 4'h3, 1'b0, n);
      end
    join

    // Single master read with a 2-cycle slave.
    slave_lat = 2;
    expect_cpl(0, 32'h0000_0002);
    fork
      do_req(0, 32'h0002_0000, 32'h0, 4'h0, 1'b0, n1);
      begin
        @(negedge clk);
        chk("grant_cycle_s_valid", 32'(bif.s_valid), 32'h0);
        @(negedge clk);
        chk("busy_s_valid", 32'(bif.s_valid), 32'h1);
        chk("busy_s_addr",  bif.s_addr,       32'h0002_0000);
        chk("busy_s_wstrb", 32'(bif.s_wstrb), 32'h0);
      end
    join
    chk("single_latency", 32'(n1), 32'd3);

    // Timeout on an m1 write.
    slave_lat = 1000;
    expect_cpl(1, 32'hDEAD_BEEF);
    do_req(1, 32'h9000_0000, 32'h1234_5678, 4'hF, 1'b0, n1);
    chk("timeout_latency",   32'(n1),        32'(T + 1));
    chk("to1_err_irq",       32'(err_irq),   32'h1);
    chk("to1_err_addr",      err_addr,       32'h9000_0000);
    chk("to1_err_master",    32'(err_master), 32'h1);

    // Second timeout before clearing keeps the first address.
    expect_cpl(0, 32'hDEAD_BEEF);
    do_req(0, 32'h9000_0100, 32'h0, 4'h0, 1'b0, n1);
    chk("to2_err_irq",    32'(err_irq),    32'h1);
    chk("to2_err_addr",   err_addr,        32'h9000_0000);
    chk("to2_err_master", 32'(err_master), 32'h1);

    // Clear coincident with a new timeout: set wins, new address captured.
    expect_cpl(0, 32'hDEAD_BEEF);
    fork
      do_req(0, 32'hA000_0000, 32'h0, 4'h0, 1'b0, n1);
      begin
        repeat (T + 1) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
      end
    join
    chk("to3_err_irq",    32'(err_irq),    32'h1);
    chk("to3_err_addr",   err_addr,        32'hA000_0000);
    chk("to3_err_master", 32'(err_master), 32'h0);

    // m0 withdraws mid-transaction; m1 is served next.
    slave_lat = 1000;
    expect_cpl(1, 32'h0000_0006);
    fork
      begin
        ma[0] = 32'h0007_0000;
        mv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mv[0] = 1'b0;
        slave_lat = 1;
      end
      begin
        int n;
        @(posedge clk);
        #1;
        do_req(1, 32'h0006_0000, 32'h1111_2222, 4'hF, 1'b0, n);
      end
    join
    chk("wd_err_addr",   err_addr,        32'hA000_0000);
    chk("wd_err_master", 32'(err_master), 32'h0);

    // Asynchronous reset in the middle of a transaction.
    slave_lat = 1000;
    ma[0] = 32'h0009_0000;
    mv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_s_valid", 32'(bif.s_valid), 32'h0);
    chk("arst_m_ready", 32'(bif.m_ready), 32'h0);
    chk("arst_s_addr",  bif.s_addr,       32'h0);
    chk("arst_err_irq", 32'(err_irq),     32'h0);
    chk("arst_err_addr", err_addr,        32'h0);
    mv[0] = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    slave_lat = 1;
    expect_cpl(0, 32'h3000_0000);
    expect_cpl(1, 32'h4000_0000);
    fork
      begin int n; do_req(0, 32'h0000_3000, 32'h0, 4'h0, 1'b0, n); end
      begin int n; do_req(1, 32'h0000_4000, 32'h0, 4'h0, 1'b0, n); end
    join

    // Fresh capture after reset, then a plain clear.
    slave_lat = 1000;
    expect_cpl(0, 32'hDEAD_BEEF);
    do_req(0, 32'hB000_0000, 32'h0, 4'h0, 1'b0, n1);
    chk("to4_err_irq",    32'(err_irq),    32'h1);
    chk("to4_err_addr",   err_addr,        32'hB000_0000);
    chk("to4_err_master", 32'(err_master), 32'h0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_err_irq",    32'(err_irq),    32'h0);
    chk("clr_err_addr",   err_addr,        32'h0);
    chk("clr_err_master", 32'(err_master), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the SoC's native valid/ready memory bus (the picorv32-style bus that feeds the address decoder and slaves). Shares the single slave-side bus between master 0 (CPU) and master 1 (DMA/debug master) with round-robin fairness. Guarantees a one-cycle bus-idle gap between transactions and terminates hung transactions with a bus-timeout error. Unmapped addresses therefore complete instead of stalling the CPU forever.

## Interface
- TIMEOUT_CYCLES, 256: cycles a granted transaction may wait for s_ready before error completion (≥2).
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.
- clk  in  1  system clock (pll_clk domain).
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- m_valid  in  2  per-master request; held high until that master's m_ready.
- m_instr  in  2  per-master instruction-fetch flag.
- m_addr  in  2x32  per-master byte address.
- m_wdata  in  2x32  per-master write data.
- m_wstrb  in  2x4  per-master byte strobes; 0 = read.
- m_ready  out  2  per-master completion, one-cycle pulse.
- m_rdata  out  32  shared read data, valid only with m_ready.
- s_valid, s_instr  out  1  slave-side request and instr flag.
- s_addr, s_wdata  out  32  slave-side address/data.
- s_wstrb  out  4  slave-side strobes.
- s_ready  in  1  slave-side completion (from decoder OR-tree).
- s_rdata  in  32  slave-side read data.
- err_irq  out  1  sticky timeout flag.
- err_addr  out  32  address of first timed-out transaction since last clear.
- err_master  out  1  master index of that transaction.
- err_clr  in  1  single-cycle clear of err_irq/err_addr/err_master.

## Operation
- States: IDLE, BUSY, ERR. Registers: owner (1 b), last (1 b, last granted master), tcnt ($clog2(TIMEOUT_CYCLES) b).
- IDLE: s_valid=0, m_ready=0. If any m_valid: owner <= pick, tcnt <= 0, go BUSY.
- Pick: only one requester → that one; both → ~last (round-robin). last <= pick.
- BUSY: s_* mirror owner's m_* combinationally; s_valid = m_valid[owner]. m_ready[owner] = s_ready; m_rdata = s_rdata. Other master's m_ready = 0.
  - s_ready → IDLE.
  - m_valid[owner] drops without s_ready (protocol violation/master reset) → IDLE, no error.
  - tcnt == TIMEOUT_CYCLES-1 and no s_ready → ERR; else tcnt++.
- ERR (one cycle): s_valid=0; m_ready[owner]=1, m_rdata=ERR_RDATA (writes discarded). If err_irq clear: capture err_addr=m_addr[owner], err_master=owner. err_irq <= 1. → IDLE.
- err_clr and new error set in same cycle: set wins (flag stays 1, new address captured).
- s_ready while IDLE or ERR: ignored.

## Timing
- Reset values: state=IDLE, owner=0, last=1 (master 0 wins first contention), tcnt=0, all m_ready=0, s_valid=0, s_addr/s_wdata=0 (mux of owner 0 gated), s_wstrb=0, err_irq=0, err_addr=0, err_master=0.
- Arbitration latency: 1 cycle (m_valid high at edge N → s_valid high after N).
- Completion: m_ready same cycle as s_ready (combinational pass-through); s_valid low the following cycle (mandatory idle gap so registered-ready slaves see select drop).
- Back-to-back throughput: one transaction per (slave latency + 2) cycles.
- Timeout: m_ready in cycle TIMEOUT_CYCLES+1 after grant cycle; err_irq visible the cycle after.
- Reset asserted mid-transaction: immediate return to IDLE, s_valid=0, no m_ready.

## Structure
- Shared package bus_pkg: state encoding (IDLE/BUSY/ERR), bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4), default ERR_RDATA.
- Sub-module rr_arbiter: combinational 2-way round-robin pick from m_valid and last; bus_arbiter owns the registers.

## Test plan
- Single master: m0 reads 0x0002_0000, slave ready 2 cycles after s_valid → m_ready[0] pulse with s_rdata, s_valid low next cycle, m1 untouched.
- Contention: both valid from reset → grants m0, m1, m0, m1 on consecutive transactions; no master starved.
- Timeout: m1 writes 0x9000_0000, s_ready never → m_ready[1] at TIMEOUT_CYCLES+1, m_rdata=0xDEAD_BEEF, err_irq=1, err_addr=0x9000_0000, err_master=1.
- Second timeout before clear: err_addr keeps first address; err_clr with concurrent timeout → err_irq stays 1, new address captured.
- Master withdraws: m0 valid drops in BUSY before s_ready → IDLE, no m_ready, no error, m1 served next.
- reset_n low mid-BUSY → all outputs at reset values asynchronously; after release m0 wins first contention.
